// File: rtl/fib_hash_arbiter.sv
// Shares one FIB hash unit between the INS and LKP requesters.
// Round-robin grant, operands latched at grant, one-cycle done pulse per transaction.
module fib_hash_arbiter #(
  parameter int HASH_LAT = 1,
  parameter int PFX_W    = 64,
  parameter int LEN_W    = 6,
  parameter int HASH_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_req,
  input  logic [PFX_W-1:0]  ins_prefix,
  input  logic [LEN_W-1:0]  ins_len,
  output logic              ins_done,
  input  logic              lkp_req,
  input  logic [PFX_W-1:0]  lkp_prefix,
  input  logic [LEN_W-1:0]  lkp_len,
  output logic              lkp_done,
  output logic [HASH_W-1:0] hash_out,
  output logic              busy,
  output logic [PFX_W-1:0]  hash_prefix_out,
  output logic [LEN_W-1:0]  hash_len_out,
  input  logic [HASH_W-1:0] hash_value_in
);

  typedef enum logic [1:0] {IDLE, HASH, DONE} state_t;
  typedef enum logic {OWN_INS, OWN_LKP} owner_t;

  state_t             state;
  owner_t             owner;
  owner_t             last_grant;
  logic [3:0]         cnt;
  logic [PFX_W-1:0]   lat_prefix;
  logic [LEN_W-1:0]   lat_len;
  logic               grant_lkp;

  // On a tie LKP wins only if INS was granted last.
  always_comb begin
    grant_lkp = lkp_req && (!ins_req || (last_grant == OWN_INS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_INS;
      last_grant <= OWN_LKP;
      cnt        <= '0;
      lat_prefix <= '0;
      lat_len    <= '0;
      hash_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ins_req || lkp_req) begin
            owner      <= grant_lkp ? OWN_LKP : OWN_INS;
            last_grant <= grant_lkp ? OWN_LKP : OWN_INS;
            lat_prefix <= grant_lkp ? lkp_prefix : ins_prefix;
            lat_len    <= grant_lkp ? lkp_len : ins_len;
            cnt        <= 4'(HASH_LAT - 1);
            state      <= HASH;
          end
        end
        HASH: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            hash_out <= hash_value_in;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy            = (state != IDLE);
    ins_done        = (state == DONE) && (owner == OWN_INS);
    lkp_done        = (state == DONE) && (owner == OWN_LKP);
    hash_prefix_out = (state == HASH) ? lat_prefix : '0;
    hash_len_out    = (state == HASH) ? lat_len : '0;
  end

endmodule
